// File: rtl/axis_rr_packet_arbiter_if.sv
// AXI4-Stream bundle joining NUM_SRC source streams, the packet arbiter and the downstream sink.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface axis_rr_packet_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 512
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        s_axis_tvalid;
  logic [NUM_SRC-1:0]        s_axis_tready;
  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]        s_axis_tlast;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic [DATA_W-1:0]         m_axis_tdata;
  logic                      m_axis_tlast;
  logic [ID_W-1:0]           m_axis_tid;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid
  );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter: one source owns the master path from its first beat until TLAST,
// with a one-cycle arbitration bubble between packets. Also counts packets and flags over-length ones.
module axis_rr_packet_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 512,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axis_rr_packet_arbiter_if.slave axis,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic                    overrun
);
  localparam int ID_W = $clog2(NUM_SRC);
  localparam int BC_W = $clog2(MAX_BEATS + 1);
  localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BEATS);
  localparam logic [BC_W-1:0] BC_WARN = BC_W'(MAX_BEATS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     w_pick;
  logic [BC_W-1:0]     r_beat_cnt;
  logic [CNT_W-1:0]    r_pkt_cnt;
  logic                r_overrun;
  logic                w_any_req;
  logic                w_beat;
  logic                w_last_beat;
  logic [NUM_SRC-1:0]  w_tready;
  logic                w_tvalid;
  logic [DATA_W-1:0]   w_tdata;
  logic                w_tlast;

  // First requester after ptr, scanning ptr+1, ptr+2, ... modulo NUM_SRC (nearest wins).
  function automatic logic [ID_W-1:0] f_rr_pick(input logic [NUM_SRC-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    int              cand;
    pick = ptr;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_SRC;
      if (req[cand]) begin
        pick = ID_W'(cand);
      end
    end
    return pick;
  endfunction

  assign w_any_req = |axis.s_axis_tvalid;
  assign w_pick    = f_rr_pick(axis.s_axis_tvalid, r_rr_ptr);

  // Next-state decode and zero-latency passthrough of the granted source
  always_comb begin
    w_state_nxt = r_state;
    w_tready    = '0;
    w_tvalid    = 1'b0;
    w_tdata     = '0;
    w_tlast     = 1'b0;
    w_beat      = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = XFER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        // Reset drops the path in the same cycle so a half-sent packet sees no further handshakes.
        if (aresetn) begin
          w_tvalid          = axis.s_axis_tvalid[r_grant];
          w_tdata           = axis.s_axis_tdata[int'(r_grant)*DATA_W +: DATA_W];
          w_tlast           = axis.s_axis_tlast[r_grant];
          w_tready[r_grant] = axis.m_axis_tready;
          w_beat            = w_tvalid & axis.m_axis_tready;
          w_last_beat       = w_beat & w_tlast;
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = XFER;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= ID_W'(NUM_SRC - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any_req) begin
        r_grant <= w_pick;
      end
      if (w_last_beat) begin
        r_rr_ptr <= r_grant;
      end
    end
  end

  // Per-packet beat count, completed-packet count and sticky over-length flag
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_last_beat) begin
        r_beat_cnt <= '0;
        r_pkt_cnt  <= r_pkt_cnt + CNT_W'(1);
      end else if (w_beat && r_beat_cnt != BC_MAX) begin
        r_beat_cnt <= r_beat_cnt + BC_W'(1);
      end
      if (w_beat && !w_tlast && r_beat_cnt >= BC_WARN) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign axis.s_axis_tready = w_tready;
  assign axis.m_axis_tvalid = w_tvalid;
  assign axis.m_axis_tdata  = w_tdata;
  assign axis.m_axis_tlast  = w_tlast;
  assign axis.m_axis_tid    = r_grant;
  assign pkt_cnt            = r_pkt_cnt;
  assign overrun            = r_overrun;
endmodule
